avalon_pio_ext: RTL and testbench

Parametrised general-purpose I/O slave for the Nios II system bus; the successor to the 2-bit output-only PIO used in the alarm CPU designs. It provides a WIDTH-bit port with per-bit direction control, atomic set/clear of output bits, synchronised inputs with edge capture, and a maskable level interrupt to the CPU IRQ line. It sits as an Avalon-MM slave with zero-wait-state combinational read data.

---
 rtl/avalon_pio_ext_pkg.sv | 16 +
 rtl/avalon_pio_ext_if.sv | 21 ++
 rtl/avalon_pio_ext_edge.sv | 40 ++++
 rtl/avalon_pio_ext.sv | 92 +++++++++
 tb/tb_avalon_pio_ext.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/avalon_pio_ext_pkg.sv
// avalon_pio_ext_pkg: register map and edge-mode encodings
// shared by the GPIO slave and its input synchroniser.
package avalon_pio_ext_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/avalon_pio_ext_if.sv
// avalon_pio_ext_if: Avalon-MM slave bus (address, chipselect,
// write_n, writedata, readdata); master drives, slave returns readdata.
interface avalon_pio_ext_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/avalon_pio_ext_edge.sv
// pio_edge_sync: SYNC_STAGES-flop input synchroniser plus delayed copy;
// ports clk/reset, in_port in, in_sync and per-bit edge_evt pulse out.
module pio_edge_sync
    import avalon_pio_ext_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] edge_evt
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0]                  in_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain   <= '0;
            in_prev <= '0;
        end else begin
            chain   <= {chain[SYNC_STAGES-2:0], in_port};
            in_prev <= in_sync;
        end
    end

    assign in_sync = chain[SYNC_STAGES-1];

    always_comb begin
        edge_evt = in_sync ^ in_prev;
        if (EDGE_TYPE == EDGE_RISE)
            edge_evt = in_sync & ~in_prev;
        else if (EDGE_TYPE == EDGE_FALL)
            edge_evt = ~in_sync & in_prev;
    end

endmodule

// File: rtl/avalon_pio_ext.sv
// avalon_pio_ext: WIDTH-bit GPIO slave with direction, set/clear,
// edge capture and masked irq; ports clk, reset, bus, in_port, out_port, oe, irq.
module avalon_pio_ext
    import avalon_pio_ext_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter int               SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    avalon_pio_ext_if.slave   bus,
    input  logic [WIDTH-1:0]  in_port,
    output logic [WIDTH-1:0]  out_port,
    output logic [WIDTH-1:0]  oe,
    output logic              irq
);

    localparam logic [31:0] LOW_MASK = 32'((64'd1 << WIDTH) - 64'd1);

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] rd_val;
    logic             unused_hi;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wd        = bus.writedata[WIDTH-1:0];
    assign unused_hi = ^(bus.writedata & ~LOW_MASK);

    pio_edge_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .in_port  (in_port),
        .in_sync  (in_sync),
        .edge_evt (edge_evt)
    );

    assign cap_clr = (wr && bus.address == ADDR_EDGECAP) ? wd : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= RESET_OUT;
            dir      <= RESET_DIR;
            irqmask  <= '0;
            edgecap  <= '0;
        end else begin
            if (wr) begin
                case (bus.address)
                    ADDR_DATA:    data_out <= wd;
                    ADDR_DIR:     dir      <= wd;
                    ADDR_IRQMASK: irqmask  <= wd;
                    ADDR_OUTSET:  data_out <= data_out | wd;
                    ADDR_OUTCLR:  data_out <= data_out & ~wd;
                    default:      ;
                endcase
            end
            // OR-ing the new event after the clear lets a same-cycle edge win
            edgecap <= (edgecap & ~cap_clr) | edge_evt;
        end
    end

    always_comb begin
        rd_val = '0;
        case (bus.address)
            ADDR_DATA:    rd_val = (dir & data_out) | (~dir & in_sync);
            ADDR_DIR:     rd_val = dir;
            ADDR_IRQMASK: rd_val = irqmask;
            ADDR_EDGECAP: rd_val = edgecap;
            default:      rd_val = '0;
        endcase
        bus.readdata              = '0;
        bus.readdata[WIDTH-1:0]   = rd_val;
    end

    assign out_port = data_out;
    assign oe       = dir;
    assign irq      = |(edgecap & irqmask);

endmodule

// File: tb/tb_avalon_pio_ext.sv
// tb_avalon_pio_ext: directed checks of two GPIO slaves, one in
// rising-edge mode and one in any-edge mode, sharing clk and reset.
module tb_avalon_pio_ext;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in0 = 8'h00;
    logic [7:0] in2 = 8'h00;
    logic [7:0] out0, oe0, out2, oe2;
    logic       irq0, irq2;
    logic [31:0] r;
    int total = 0;
    int bad   = 0;

    avalon_pio_ext_if b0 ();
    avalon_pio_ext_if b2 ();

    always #5 clk = ~clk;

    avalon_pio_ext #(
        .WIDTH(8), .RESET_OUT(8'hA5), .RESET_DIR(8'h0F),
        .EDGE_TYPE(0), .SYNC_STAGES(2)
    ) dut0 (
        .clk(clk), .reset(rst), .bus(b0), .in_port(in0),
        .out_port(out0), .oe(oe0), .irq(irq0)
    );

    avalon_pio_ext #(
        .WIDTH(8), .RESET_OUT(8'hA5), .RESET_DIR(8'h0F),
        .EDGE_TYPE(2), .SYNC_STAGES(2)
    ) dut2 (
        .clk(clk), .reset(rst), .bus(b2), .in_port(in2),
        .out_port(out2), .oe(oe2), .irq(irq2)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bwr(input int w, input logic [2:0] a,
                       input logic [31:0] d);
        if (w == 0) begin
            b0.chipselect = 1'b1; b0.write_n = 1'b0;
            b0.address = a; b0.writedata = d;
        end else begin
            b2.chipselect = 1'b1; b2.write_n = 1'b0;
            b2.address = a; b2.writedata = d;
        end
        tick(1);
        b0.chipselect = 1'b0; b0.write_n = 1'b1;
        b2.chipselect = 1'b0; b2.write_n = 1'b1;
    endtask

    task automatic brd(input int w, input logic [2:0] a,
                       output logic [31:0] d);
        if (w == 0) begin
            b0.chipselect = 1'b1; b0.write_n = 1'b1; b0.address = a;
            #1 d = b0.readdata;
        end else begin
            b2.chipselect = 1'b1; b2.write_n = 1'b1; b2.address = a;
            #1 d = b2.readdata;
        end
        b0.chipselect = 1'b0;
        b2.chipselect = 1'b0;
    endtask

    initial begin
        b0.chipselect = 1'b0; b0.write_n = 1'b1;
        b0.address = 3'd0; b0.writedata = 32'h0;
        b2.chipselect = 1'b0; b2.write_n = 1'b1;
        b2.address = 3'd0; b2.writedata = 32'h0;
        in0 = 8'h30;

        // reset values
        tick(2);
        rst = 1'b0;
        chk("rst_out", 32'(out0), 32'hA5);
        chk("rst_oe", 32'(oe0), 32'h0F);
        chk("rst_irq", 32'(irq0), 32'h0);
        brd(0, 3'd0, r); chk("rst_data_rd", r, 32'h05);
        brd(0, 3'd2, r); chk("rst_mask_rd", r, 32'h0);
        brd(0, 3'd3, r); chk("rst_cap_rd", r, 32'h0);

        // high input after reset: synced read and one rising capture
        tick(4);
        brd(0, 3'd0, r); chk("sync_data_rd", r, 32'h35);
        brd(0, 3'd3, r); chk("post_rst_cap", r, 32'h30);
        brd(1, 3'd3, r); chk("quiet_cap2", r, 32'h0);
        bwr(0, 3'd3, 32'hFF);
        brd(0, 3'd3, r); chk("cap_w1c", r, 32'h0);
        in0 = 8'h00;

        // data / set / clear
        bwr(0, 3'd0, 32'h00); chk("data_wr", 32'(out0), 32'h00);
        bwr(0, 3'd4, 32'h81); chk("outset", 32'(out0), 32'h81);
        bwr(0, 3'd5, 32'h01); chk("outclr", 32'(out0), 32'h80);
        brd(0, 3'd4, r); chk("rd_outset", r, 32'h0);
        brd(0, 3'd5, r); chk("rd_outclr", r, 32'h0);
        brd(0, 3'd6, r); chk("rd_addr6", r, 32'h0);
        bwr(0, 3'd1, 32'hFFFF_FF0F);
        brd(0, 3'd1, r); chk("dir_upper_ignored", r, 32'h0F);
        brd(0, 3'd3, r); chk("fall_no_cap", r, 32'h0);

        // rising edge on bit 3, masked in
        bwr(0, 3'd2, 32'h08);
        in0 = 8'h08;
        tick(2);
        brd(0, 3'd3, r); chk("cap_early", r, 32'h0);
        chk("irq_early", 32'(irq0), 32'h0);
        tick(1);
        brd(0, 3'd3, r); chk("cap_rise", r, 32'h08);
        chk("irq_rise", 32'(irq0), 32'h1);
        bwr(0, 3'd3, 32'h08);
        chk("irq_clr", 32'(irq0), 32'h0);
        in0 = 8'h00;
        tick(4);
        brd(0, 3'd3, r); chk("cap_fall_none", r, 32'h0);
        chk("irq_fall_none", 32'(irq0), 32'h0);

        // clear racing a new event: event wins
        in0 = 8'h08;
        tick(3);
        chk("irq_set_again", 32'(irq0), 32'h1);
        in0 = 8'h00;
        tick(3);
        in0 = 8'h08;
        tick(2);
        bwr(0, 3'd3, 32'h08);
        brd(0, 3'd3, r); chk("race_cap", r, 32'h08);
        chk("race_irq", 32'(irq0), 32'h1);
        tick(2);
        bwr(0, 3'd3, 32'h08);
        chk("quiet_clr_irq", 32'(irq0), 32'h0);
        brd(0, 3'd3, r); chk("quiet_clr_cap", r, 32'h0);

        // any-edge mode on bit 0, mask 0 then 1
        in2 = 8'h01;
        tick(4);
        in2 = 8'h00;
        tick(4);
        brd(1, 3'd3, r); chk("any_cap", r, 32'h01);
        chk("any_irq_masked", 32'(irq2), 32'h0);
        bwr(1, 3'd2, 32'h01);
        chk("any_irq_unmask", 32'(irq2), 32'h1);

        // reset overrides a concurrent write
        in0 = 8'h00;
        tick(4);
        in0 = 8'hFF;
        tick(4);
        brd(0, 3'd3, r); chk("cap_all", r, 32'hFF);
        bwr(0, 3'd0, 32'hFF); chk("out_all", 32'(out0), 32'hFF);
        bwr(0, 3'd2, 32'hFF); chk("irq_all", 32'(irq0), 32'h1);
        b0.chipselect = 1'b1; b0.write_n = 1'b0;
        b0.address = 3'd0; b0.writedata = 32'h00;
        rst = 1'b1;
        tick(1);
        b0.chipselect = 1'b0; b0.write_n = 1'b1;
        rst = 1'b0;
        chk("rst2_out", 32'(out0), 32'hA5);
        chk("rst2_oe", 32'(oe0), 32'h0F);
        chk("rst2_irq", 32'(irq0), 32'h0);
        brd(0, 3'd3, r); chk("rst2_cap", r, 32'h0);
        brd(0, 3'd2, r); chk("rst2_mask", r, 32'h0);
        chk("rst2_irq2", 32'(irq2), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
